avalon_copy_master: RTL and testbench

- Avalon-MM master that copies a block of 32-bit words from one word address range to another, one word at a time.
- Drives the s1 slave port of the on-chip RAM; it is the initiator side of that RAM's read/write interface.
- Control side starts it with a pulse and gets busy/done status. Intended use: buffer move or clear-by-copy inside the SoPC.

---
 rtl/avalon_copy_master_pkg.sv | 19 +
 rtl/avalon_copy_master.sv | 144 ++++++++++++++
 tb/tb_avalon_copy_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_copy_master_pkg.sv
// Shared types and defaults for the Avalon-MM block copy master.
// Holds the FSM state encoding and the default bus widths.
package avalon_copy_master_pkg;

  localparam int unsigned DefAddrW = 13;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefLenW  = 14;

  localparam logic [DefDataW/8-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StFinish
  } state_e;

endpackage

// File: rtl/avalon_copy_master.sv
// Avalon-MM master that copies len words from src_addr to dst_addr, one word at a time:
// read, wait for readdatavalid, write, repeat. Pointers wrap modulo 2^ADDR_W.
module avalon_copy_master
  import avalon_copy_master_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    xfer_count,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                busy_q, busy_d;
  logic [LEN_W-1:0]    cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          len_d = len;
          cnt_d = '0;
          if (len == '0) begin
            state_d = StFinish;
          end else begin
            state_d = StRdReq;
            busy_d  = 1'b1;
          end
        end
      end
      StRdReq: begin
        if (!avm_waitrequest) begin
          src_d   = src_q + ADDR_W'(1);
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (avm_readdatavalid) begin
          buf_d   = avm_readdata;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        if (!avm_waitrequest) begin
          dst_d = dst_q + ADDR_W'(1);
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = StFinish;
            // busy drops in the same cycle done rises
            busy_d  = 1'b0;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_byteenable = '0;
    done           = 1'b0;
    unique case (state_q)
      StRdReq: begin
        avm_read       = 1'b1;
        avm_address    = src_q;
        avm_byteenable = BE_ALL;
      end
      StWrReq: begin
        avm_write      = 1'b1;
        avm_address    = dst_q;
        avm_byteenable = BE_ALL;
      end
      StFinish: done = 1'b1;
      default: ;
    endcase
  end

  assign avm_writedata = buf_q;
  assign busy          = busy_q;
  assign xfer_count    = cnt_q;

endmodule

// File: tb/tb_avalon_copy_master.sv
// Randomized bench for avalon_copy_master: an on-chip RAM slave with random stalls and a
// word-level copy model that predicts read/write address streams, data and final memory.
module tb_avalon_copy_master;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LW = 14;
  localparam int MemWords = 8192;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done;
  logic [LW-1:0] xfer_count;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [3:0]    avm_byteenable;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;
  logic          avm_readdatavalid = 1'b0;

  avalon_copy_master dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .len               (len),
    .busy              (busy),
    .done              (done),
    .xfer_count        (xfer_count),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_byteenable    (avm_byteenable),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram     [MemWords];
  logic [DW-1:0] exp_mem [MemWords];
  bit            wait_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // RAM slave: one-cycle read latency, optional random waitrequest
  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (avm_read && !avm_waitrequest) begin
      avm_readdatavalid <= 1'b1;
      avm_readdata      <= ram[avm_address];
    end
    if (avm_write && !avm_waitrequest) ram[avm_address] = avm_writedata;
    avm_waitrequest <= wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  int            rd_log[$];
  int            wa_log[$];
  logic [DW-1:0] wd_log[$];
  int            done_cnt = 0;
  int            stab_err = 0;
  int            both_err = 0;
  int            be_err = 0;
  bit            prv_stall = 1'b0;
  bit            prv_rd, prv_wr;
  logic [AW-1:0] prv_addr;
  logic [DW-1:0] prv_wd;

  always @(negedge clk) begin
    if (!reset_n) begin
      prv_stall = 1'b0;
    end else begin
      if (avm_read && !avm_waitrequest) rd_log.push_back(int'(avm_address));
      if (avm_write && !avm_waitrequest) begin
        wa_log.push_back(int'(avm_address));
        wd_log.push_back(avm_writedata);
      end
      if (done) done_cnt++;
      if (avm_read && avm_write) both_err++;
      if ((avm_read || avm_write) ? (avm_byteenable != 4'hF) : (avm_byteenable != 4'h0)) be_err++;
      if (prv_stall) begin
        if (prv_rd && !(avm_read && avm_address == prv_addr)) stab_err++;
        if (prv_wr && !(avm_write && avm_address == prv_addr && avm_writedata == prv_wd))
          stab_err++;
      end
      prv_stall = avm_waitrequest && (avm_read || avm_write);
      prv_rd    = avm_read;
      prv_wr    = avm_write;
      prv_addr  = avm_address;
      prv_wd    = avm_writedata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
    done_cnt = 0;
    stab_err = 0;
    both_err = 0;
    be_err   = 0;
  endtask

  // restart_at > 0 pulses a second (to be ignored) start in that cycle of the copy
  task automatic run_copy(input string tag, input int s, input int d, input int n,
                          input bit we, input int restart_at);
    int            exp_rd[$];
    int            exp_wa[$];
    logic [DW-1:0] exp_wd[$];
    int            k, bad;
    bit            seen, busy_bad;
    logic          busy_at_done;
    logic [LW-1:0] cnt_at_done;
    exp_mem = ram;
    for (int i = 0; i < n; i++) begin
      int ra, wa;
      ra = (s + i) % MemWords;
      wa = (d + i) % MemWords;
      exp_rd.push_back(ra);
      exp_wa.push_back(wa);
      exp_mem[wa] = exp_mem[ra];
      exp_wd.push_back(exp_mem[wa]);
    end
    clear_logs();
    wait_en  = we;
    start    = 1'b1;
    src_addr = AW'(s);
    dst_addr = AW'(d);
    len      = LW'(n);
    tick();
    start = 1'b0;
    k = 1;
    seen = 1'b0;
    busy_bad = 1'b0;
    busy_at_done = 1'b1;
    cnt_at_done = '0;
    while (!seen && k < 60 * n + 20) begin
      if (done) begin
        seen = 1'b1;
        busy_at_done = busy;
        cnt_at_done = xfer_count;
      end else begin
        if (busy !== (n > 0)) busy_bad = 1'b1;
        if (k == restart_at) begin
          start    = 1'b1;
          src_addr = AW'($urandom);
          dst_addr = AW'($urandom);
          len      = LW'($urandom_range(1, 30));
        end else begin
          start = 1'b0;
        end
        tick();
        k++;
      end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 64'(seen), 64'd1);
    check({tag, ".busy_at_done"}, 64'(busy_at_done), 64'd0);
    check({tag, ".count_at_done"}, 64'(cnt_at_done), 64'(n));
    if (!we) check({tag, ".latency"}, 64'(k), 64'(3 * n + 1));
    wait_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, ".busy_window"}, 64'(busy_bad), 64'd0);
    check({tag, ".count_hold"}, 64'(xfer_count), 64'(n));
    check({tag, ".n_reads"}, 64'(rd_log.size()), 64'(n));
    check({tag, ".n_writes"}, 64'(wa_log.size()), 64'(n));
    bad = 0;
    for (int i = 0; i < n && i < rd_log.size() && i < wa_log.size(); i++) begin
      if (rd_log[i] != exp_rd[i] || wa_log[i] != exp_wa[i] || wd_log[i] !== exp_wd[i]) bad++;
    end
    check({tag, ".stream"}, 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < MemWords; i++) if (ram[i] !== exp_mem[i]) bad++;
    check({tag, ".memory"}, 64'(bad), 64'd0);
    check({tag, ".stable"}, 64'(stab_err), 64'd0);
    check({tag, ".rd_wr_excl"}, 64'(both_err), 64'd0);
    check({tag, ".byteenable"}, 64'(be_err), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".ctl"}, {busy, done, xfer_count, avm_read, avm_write, avm_address,
                          avm_byteenable}, 64'd0);
    check({tag, ".wdata"}, 64'(avm_writedata), 64'd0);
  endtask

  initial begin
    int s, d, n, k;
    bit found;
    for (int i = 0; i < MemWords; i++) ram[i] = $urandom;
    ram[0] = 32'h11;
    ram[1] = 32'h22;
    ram[2] = 32'h33;
    ram[3] = 32'h44;
    #1;
    check_outputs_zero("reset");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check_outputs_zero("post_reset");

    run_copy("basic4", 0, 100, 4, 1'b0, 0);
    for (int i = 0; i < 4; i++) check("basic4.dst_word", 64'(ram[100 + i]), 64'(32'h11 * (i + 1)));

    run_copy("len0", 5, 50, 0, 1'b0, 0);
    run_copy("stall16", int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)), 16, 1'b1,
             0);
    run_copy("wrap", 8190, 8191, 3, 1'b0, 0);
    run_copy("restart", 300, 400, 8, 1'b1, 7);

    // reset while the second word's write is on the bus
    clear_logs();
    start = 1'b1;
    src_addr = AW'(200);
    dst_addr = AW'(300);
    len = LW'(4);
    tick();
    start = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 50) begin
      if (avm_write && xfer_count == LW'(1)) found = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    check("midreset.reached_wr2", 64'(found), 64'd1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("midreset.no_done", 64'(done_cnt), 64'd0);
    check("midreset.idle_busy", 64'(busy), 64'd0);
    run_copy("after_reset", 600, 10, 5, 1'b1, 0);

    for (int t = 0; t < 6; t++) begin
      s = int'($urandom_range(0, 8191));
      n = int'($urandom_range(1, 24));
      // half the runs overlap the source range
      d = (t % 2 == 0) ? (s + int'($urandom_range(1, 5))) % MemWords
                       : int'($urandom_range(0, 8191));
      run_copy($sformatf("rand%0d", t), s, d, n, 1'($urandom_range(0, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
